point_cloud_feeder: RTL and testbench
=====================================

# point_cloud_feeder

Parametrised point-cloud streaming source for the DROR controller. It holds a point cloud in a lane-banked on-chip store, either loaded point by point or generated synthetically as x=y=z=index. For every batch of CORE_NUMBER query points it emits one core beat, then sweeps the whole cloud as DISTANCE_MODULES-wide feeder beats. Both outputs use valid/ready handshakes. It replaces free-running counter stimulus with a sequenced, back-pressurable, size-aware source that can drive the controller in simulation and on hardware.

## Interface
- N, 16, coordinate width in bits
- DISTANCE_MODULES, 32, points per feeder beat (lanes)
- CORE_NUMBER, 2, points per core beat; DISTANCE_MODULES % CORE_NUMBER == 0
- MAX_POINTS, 1024, store capacity; multiple of DISTANCE_MODULES
- AW, $clog2(MAX_POINTS), point index width

Ports:
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high
- load_valid  in  1  point write request
- load_ready  out  1  store accepts a point
- load_x, load_y, load_z  in  N each  point coordinates
- start  in  1  begin a run (pulse)
- synthetic_mode  in  1  sampled at start; 1 = coordinates equal the point index
- point_cloud_size  in  AW+1  sampled at start; number of valid points
- core_valid / core_ready  out / in  1 / 1  core beat handshake
- core_x, core_y, core_z  out  N*CORE_NUMBER each  packed query points, lane 0 in LSBs
- core_mask  out  CORE_NUMBER  per-lane valid (index < size)
- core_base  out  AW  index of lane 0
- feed_valid / feed_ready  out / in  1 / 1  feeder beat handshake
- feed_x, feed_y, feed_z  out  N*DISTANCE_MODULES each  packed candidate points
- feed_mask  out  DISTANCE_MODULES  per-lane valid
- feed_base  out  AW  index of lane 0
- feed_last  out  1  final feeder beat for the current core batch
- busy  out  1  run in progress
- done  out  1  run finished; held until the next accepted start or reset

## Operation
- Store: MAX_POINTS entries of 3N bits. Point i sits in lane i % DISTANCE_MODULES, row i / DISTANCE_MODULES. Reads are combinational, one full row per read.
- Load: a write pointer starts at 0 and increments on each load_valid && load_ready. load_ready = (state IDLE or DONE) && ptr < MAX_POINTS. The pointer clears on reset and on an accepted start.
- Size: the sampled size saturates at MAX_POINTS. F = ceil(size / DISTANCE_MODULES) feeder beats per batch. B = ceil(size / CORE_NUMBER) core batches per run.
- Synthetic mode: every lane coordinate equals the zero-extended or truncated index, masked by index < size. The store is not read.
- FSM states are IDLE, CORE, FEED and DONE.
  - IDLE/DONE + start: if size == 0, go to DONE; otherwise go to CORE with core_pos=0.
  - CORE: core_valid=1. On handshake, go to FEED with feed_row=0.
  - FEED: feed_valid=1. On handshake, feed_row++. If feed_last: core_pos += CORE_NUMBER, then go to DONE if core_pos ≥ size, otherwise go to CORE.
  - start in CORE or FEED is ignored.
- feed_last = (feed_row == F-1). Masks clear the lanes where index ≥ size; masked coordinates are driven 0.
- Output data, masks, base and last are registered. They stay stable while valid && !ready.
- busy = state is CORE or FEED.
- Reset values: all valids 0, done 0, busy 0, load_ready 1, all data, masks and bases 0, state IDLE.
- Reset mid-run drops the run immediately. The store contents are kept, but the load pointer goes to 0.

## Timing
- Start accepted at cycle t: core_valid=1 at t+1.
- Core handshake at t: feed_valid=1 with row 0 at t+1.
- With feed_ready held high, feeder beats go back-to-back, one per cycle.
- Last feeder handshake at t: at t+1, either core_valid=1 for the next batch or done=1.
- A batch costs 1+F cycles with no back-pressure. A run costs B·(1+F)+1 cycles from start to done.
- size==0: done=1 at t+1 and no beats are issued.
- A load accepted at t is readable by a start accepted at t+1.

## Structure
- Shared package point_cloud_pkg holds:
  - the point struct (x, y, z of N bits)
  - the FSM state enum
  - ceil-divide and lane/row index helpers
- Natural sub-module: point_store, the lane-banked store with a sequential write port and a full-row combinational read port.

## Test plan
- Synthetic run, DISTANCE_MODULES=4, CORE_NUMBER=2, size=6, ready tied high:
  - 3 core beats with core_base 0, 2, 4, each followed by 2 feed beats with feed_base 0 and 4.
  - Second feed beat feed_mask=4'b0011, feed_last=1.
  - done after 3·3+1 cycles.
- Memory mode: load 8 points with x=10+i, then start with size=8. Feeder beat 0 carries feed_x lanes {10,11,12,13}; core beat 1 carries {12,13}.
- Back-pressure: hold feed_ready=0 for 5 cycles mid-sweep. feed_valid and all feed data stay unchanged, and no beat is skipped or repeated.
- Boundaries:
  - size=0 gives done the next cycle with no valids.
  - size=MAX_POINTS+5 saturates, so the final core_base is MAX_POINTS-CORE_NUMBER.
  - With odd size=5, the last core_mask=2'b01.
- Load full: after MAX_POINTS loads, load_ready=0. A further load_valid writes nothing, and the pointer stays at MAX_POINTS.
- Reset during FEED drops all valids, busy and done to 0 on the next cycle. A restart then reproduces the full sequence from core_base 0.

Source files
------------

// File: rtl/point_cloud_pkg.sv
// Shared types and index helpers for the point-cloud feeder and its store.
package point_cloud_pkg;
  localparam int COORD_W = 16;

  // Default-width point record (x, y, z).
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  typedef enum logic [1:0] {S_IDLE, S_CORE, S_FEED, S_DONE} state_t;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int lane_of(input int idx, input int lanes);
    return idx % lanes;
  endfunction

  function automatic int row_of(input int idx, input int lanes);
    return idx / lanes;
  endfunction
endpackage

// File: rtl/point_store.sv
// Lane-banked point store: one-point write port, full-row combinational read port.
module point_store #(
  parameter int N     = 16,
  parameter int LANES = 32,
  parameter int ROWS  = 32,
  parameter int RW    = 5,
  parameter int LW    = 5
) (
  input  logic                         clock,
  input  logic                         wr_en,
  input  logic [RW-1:0]                wr_row,
  input  logic [LW-1:0]                wr_lane,
  input  logic [3*N-1:0]               wr_data,
  input  logic [RW-1:0]                rd_row,
  output logic [LANES-1:0][3*N-1:0]    rd_data
);
  // Contents survive reset on purpose: a reload is not needed after an abort.
  logic [LANES-1:0][3*N-1:0] mem [ROWS];

  always_ff @(posedge clock)
    if (wr_en) mem[wr_row][wr_lane] <= wr_data;

  assign rd_data = mem[rd_row];
endmodule

// File: rtl/point_cloud_feeder.sv
// Sequenced point-cloud source: one core beat per CORE_NUMBER query points, then a full-cloud sweep.
module point_cloud_feeder
  import point_cloud_pkg::*;
#(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 32,
  parameter int CORE_NUMBER      = 2,
  parameter int MAX_POINTS       = 1024,
  parameter int AW               = $clog2(MAX_POINTS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [N-1:0]                    load_x,
  input  logic [N-1:0]                    load_y,
  input  logic [N-1:0]                    load_z,
  input  logic                            start,
  input  logic                            synthetic_mode,
  input  logic [AW:0]                     point_cloud_size,
  output logic                            core_valid,
  input  logic                            core_ready,
  output logic [N*CORE_NUMBER-1:0]        core_x,
  output logic [N*CORE_NUMBER-1:0]        core_y,
  output logic [N*CORE_NUMBER-1:0]        core_z,
  output logic [CORE_NUMBER-1:0]          core_mask,
  output logic [AW-1:0]                   core_base,
  output logic                            feed_valid,
  input  logic                            feed_ready,
  output logic [N*DISTANCE_MODULES-1:0]   feed_x,
  output logic [N*DISTANCE_MODULES-1:0]   feed_y,
  output logic [N*DISTANCE_MODULES-1:0]   feed_z,
  output logic [DISTANCE_MODULES-1:0]     feed_mask,
  output logic [AW-1:0]                   feed_base,
  output logic                            feed_last,
  output logic                            busy,
  output logic                            done
);
  localparam int DM   = DISTANCE_MODULES;
  localparam int CN   = CORE_NUMBER;
  localparam int ROWS = MAX_POINTS / DM;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW   = (DM > 1) ? $clog2(DM) : 1;
  localparam logic [AW:0] MAXP = (AW+1)'(MAX_POINTS);

  state_t state, state_n;
  logic [AW:0] ptr, size_r, size_n, core_pos, core_pos_n, feed_row, feed_row_n;
  logic synth_r, synth_n, load_core, load_feed, wr_en, start_ok, f_last_n;
  logic [RW-1:0] rd_row, wr_row;
  logic [LW-1:0] wr_lane;
  logic [DM-1:0][3*N-1:0] rd_data;
  logic [DM-1:0][N-1:0] fx, fy, fz, fx_n, fy_n, fz_n;
  logic [CN-1:0][N-1:0] cx, cy, cz, cx_n, cy_n, cz_n;
  logic [DM-1:0] fm_n;
  logic [CN-1:0] cm_n;
  int rd_row_i;

  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign load_ready = (state == S_IDLE || state == S_DONE) && (ptr < MAXP);
  assign wr_en      = load_valid && load_ready;
  assign wr_row     = RW'(row_of(int'(ptr), DM));
  assign wr_lane    = LW'(lane_of(int'(ptr), DM));
  assign core_valid = (state == S_CORE);
  assign feed_valid = (state == S_FEED);
  assign busy       = core_valid || feed_valid;
  assign done       = (state == S_DONE);
  assign {core_x, core_y, core_z} = {cx, cy, cz};
  assign {feed_x, feed_y, feed_z} = {fx, fy, fz};

  point_store #(.N(N), .LANES(DM), .ROWS(ROWS), .RW(RW), .LW(LW)) u_store (
    .clock(clock), .wr_en(wr_en), .wr_row(wr_row), .wr_lane(wr_lane),
    .wr_data({load_x, load_y, load_z}), .rd_row(rd_row), .rd_data(rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    size_n     = size_r;
    synth_n    = synth_r;
    core_pos_n = core_pos;
    feed_row_n = feed_row;
    load_core  = 1'b0;
    load_feed  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        size_n     = (point_cloud_size > MAXP) ? MAXP : point_cloud_size;
        synth_n    = synthetic_mode;
        core_pos_n = '0;
        feed_row_n = '0;
        if (size_n == '0) state_n = S_DONE;
        else begin state_n = S_CORE; load_core = 1'b1; end
      end
      S_CORE: if (core_ready) begin
        state_n = S_FEED; feed_row_n = '0; load_feed = 1'b1;
      end
      S_FEED: if (feed_ready) begin
        if (feed_last) begin
          core_pos_n = core_pos + (AW+1)'(CN);
          if (core_pos_n >= size_r) state_n = S_DONE;
          else begin state_n = S_CORE; load_core = 1'b1; end
        end else begin
          feed_row_n = feed_row + 1'b1; load_feed = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One read port serves both beat kinds: the row holding the next beat's points.
  assign rd_row_i = (state_n == S_CORE) ? row_of(int'(core_pos_n), DM) : int'(feed_row_n);
  assign rd_row   = (rd_row_i < ROWS) ? RW'(rd_row_i) : '0;
  assign f_last_n = (int'(feed_row_n) == cdiv(int'(size_n), DM) - 1);

  always_comb begin : build
    int idx, lane0;
    logic [LW-1:0] lsel;
    for (int j = 0; j < DM; j++) begin
      idx     = int'(feed_row_n) * DM + j;
      fm_n[j] = (idx < int'(size_n));
      fx_n[j] = '0; fy_n[j] = '0; fz_n[j] = '0;
      if (fm_n[j]) begin
        if (synth_n) begin
          fx_n[j] = N'(idx); fy_n[j] = N'(idx); fz_n[j] = N'(idx);
        end else begin
          fx_n[j] = rd_data[j][3*N-1:2*N];
          fy_n[j] = rd_data[j][2*N-1:N];
          fz_n[j] = rd_data[j][N-1:0];
        end
      end
    end
    // Core batches never straddle a row because DM is a multiple of CN.
    lane0 = lane_of(int'(core_pos_n), DM);
    for (int k = 0; k < CN; k++) begin
      idx     = int'(core_pos_n) + k;
      lsel    = LW'(lane0 + k);
      cm_n[k] = (idx < int'(size_n));
      cx_n[k] = '0; cy_n[k] = '0; cz_n[k] = '0;
      if (cm_n[k]) begin
        if (synth_n) begin
          cx_n[k] = N'(idx); cy_n[k] = N'(idx); cz_n[k] = N'(idx);
        end else begin
          cx_n[k] = rd_data[lsel][3*N-1:2*N];
          cy_n[k] = rd_data[lsel][2*N-1:N];
          cz_n[k] = rd_data[lsel][N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0; size_r <= '0; synth_r <= 1'b0; core_pos <= '0; feed_row <= '0;
      cx <= '0; cy <= '0; cz <= '0; core_mask <= '0; core_base <= '0;
      fx <= '0; fy <= '0; fz <= '0; feed_mask <= '0; feed_base <= '0; feed_last <= 1'b0;
    end else begin
      size_r   <= size_n;
      synth_r  <= synth_n;
      core_pos <= core_pos_n;
      feed_row <= feed_row_n;
      if (start_ok)   ptr <= '0;
      else if (wr_en) ptr <= ptr + 1'b1;
      if (load_core) begin
        cx <= cx_n; cy <= cy_n; cz <= cz_n;
        core_mask <= cm_n;
        core_base <= AW'(core_pos_n);
      end
      if (load_feed) begin
        fx <= fx_n; fy <= fy_n; fz <= fz_n;
        feed_mask <= fm_n;
        feed_base <= AW'(int'(feed_row_n) * DM);
        feed_last <= f_last_n;
      end
    end
  end
endmodule

// File: tb/tb_point_cloud_feeder.sv
// Directed bench for point_cloud_feeder with DM=4, CN=2, MAX_POINTS=16.
module tb_point_cloud_feeder;
  import point_cloud_pkg::*;
  localparam int N = 16, DM = 4, CN = 2, MAXP = 16, AW = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic load_valid = 1'b0, load_ready;
  logic [N-1:0] load_x = '0, load_y = '0, load_z = '0;
  logic start = 1'b0, synthetic_mode = 1'b0;
  logic [AW:0] point_cloud_size = '0;
  logic core_valid, core_ready = 1'b1;
  logic [N*CN-1:0] core_x, core_y, core_z;
  logic [CN-1:0] core_mask;
  logic [AW-1:0] core_base, feed_base;
  logic feed_valid, feed_ready = 1'b1, feed_last, busy, done;
  logic [N*DM-1:0] feed_x, feed_y, feed_z;
  logic [DM-1:0] feed_mask;

  point_cloud_feeder #(.N(N), .DISTANCE_MODULES(DM), .CORE_NUMBER(CN), .MAX_POINTS(MAXP), .AW(AW)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_y(load_y), .load_z(load_z), .start(start),
    .synthetic_mode(synthetic_mode), .point_cloud_size(point_cloud_size),
    .core_valid(core_valid), .core_ready(core_ready), .core_x(core_x), .core_y(core_y),
    .core_z(core_z), .core_mask(core_mask), .core_base(core_base),
    .feed_valid(feed_valid), .feed_ready(feed_ready), .feed_x(feed_x), .feed_y(feed_y),
    .feed_z(feed_z), .feed_mask(feed_mask), .feed_base(feed_base), .feed_last(feed_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, done_cyc;
  logic [AW-1:0]   cb_q[$], fb_q[$];
  logic [CN-1:0]   cm_q[$];
  logic [DM-1:0]   fm_q[$];
  logic            fl_q[$];
  logic [N*CN-1:0] cx_q[$], cz_q[$];
  logic [N*DM-1:0] fx_q[$];
  int exp_cb[3] = '{0, 2, 4};
  int exp_fb[6] = '{0, 4, 0, 4, 0, 4};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Starts a run and logs every handshake until done or the cycle limit.
  task automatic run(input logic [AW:0] sz, input logic syn, input int limit);
    cb_q.delete(); fb_q.delete(); cm_q.delete(); fm_q.delete();
    fl_q.delete(); cx_q.delete(); cz_q.delete(); fx_q.delete();
    start = 1'b1; synthetic_mode = syn; point_cloud_size = sz;
    step();
    start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      if (done) begin done_cyc = c; break; end
      if (core_valid && core_ready) begin
        cb_q.push_back(core_base); cm_q.push_back(core_mask);
        cx_q.push_back(core_x); cz_q.push_back(core_z);
      end
      if (feed_valid && feed_ready) begin
        fb_q.push_back(feed_base); fm_q.push_back(feed_mask);
        fl_q.push_back(feed_last); fx_q.push_back(feed_x);
      end
      step();
    end
  endtask

  task automatic load_pt(input point_t p);
    load_valid = 1'b1; load_x = p.x; load_y = p.y; load_z = p.z;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_core_valid", 64'(core_valid), 64'd0);
    chk("rst_feed_valid", 64'(feed_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_feed_mask", 64'(feed_mask), 64'd0);
    chk("rst_feed_x", feed_x, 64'd0);

    // Synthetic size 6: B=3, F=2
    run(5'd6, 1'b1, 50);
    chk("syn6_done_cyc", 64'(done_cyc), 64'd10);
    chk("syn6_ncore", 64'(cb_q.size()), 64'd3);
    chk("syn6_nfeed", 64'(fb_q.size()), 64'd6);
    for (int i = 0; i < 3; i++) chk($sformatf("syn6_core_base%0d", i), 64'(cb_q[i]), 64'(exp_cb[i]));
    for (int i = 0; i < 6; i++) chk($sformatf("syn6_feed_base%0d", i), 64'(fb_q[i]), 64'(exp_fb[i]));
    chk("syn6_mask1", 64'(fm_q[1]), 64'h3);
    chk("syn6_last0", 64'(fl_q[0]), 64'd0);
    chk("syn6_last1", 64'(fl_q[1]), 64'd1);
    chk("syn6_feed_x1", fx_q[1], 64'h0000_0000_0005_0004);
    chk("syn6_core_x2", 64'(cx_q[2]), 64'h0005_0004);

    // Memory mode: x=10+i, y=20+i, z=30+i; start right after the last load
    for (int i = 0; i < 8; i++) load_pt('{x: 16'(10 + i), y: 16'(20 + i), z: 16'(30 + i)});
    run(5'd8, 1'b0, 60);
    chk("mem8_done_cyc", 64'(done_cyc), 64'd13);
    chk("mem8_feed_x0", fx_q[0], 64'h000d_000c_000b_000a);
    chk("mem8_core_base1", 64'(cb_q[1]), 64'd2);
    chk("mem8_core_x1", 64'(cx_q[1]), 64'h000d_000c);
    chk("mem8_core_z0", 64'(cz_q[0]), 64'h001f_001e);

    // Back-pressure on feeder row 1 of the first batch
    start = 1'b1; synthetic_mode = 1'b1; point_cloud_size = 5'd16;
    step();
    start = 1'b0;
    chk("bp_core_valid", 64'(core_valid), 64'd1);
    step();
    chk("bp_row0_base", 64'(feed_base), 64'd0);
    step();
    feed_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), 64'(feed_valid), 64'd1);
      chk($sformatf("bp_hold_x%0d", i), feed_x, 64'h0007_0006_0005_0004);
      chk($sformatf("bp_hold_base%0d", i), 64'(feed_base), 64'd4);
      if (i < 5) step();
    end
    feed_ready = 1'b1;
    step();
    chk("bp_row2_base", 64'(feed_base), 64'd8);
    chk("bp_row2_last", 64'(feed_last), 64'd0);
    step();
    chk("bp_row3_base", 64'(feed_base), 64'd12);
    chk("bp_row3_last", 64'(feed_last), 64'd1);
    chk("bp_row3_mask", 64'(feed_mask), 64'hf);
    step();
    chk("bp_next_core_valid", 64'(core_valid), 64'd1);
    chk("bp_next_core_base", 64'(core_base), 64'd2);
    for (int c = 0; c < 100 && !done; c++) step();
    chk("bp_done", 64'(done), 64'd1);

    // size 0: done next cycle, no beats
    run(5'd0, 1'b1, 10);
    chk("zero_done_cyc", 64'(done_cyc), 64'd1);
    chk("zero_ncore", 64'(cb_q.size()), 64'd0);
    chk("zero_nfeed", 64'(fb_q.size()), 64'd0);

    // Saturation: 21 -> 16, B=8, F=4
    run(5'd21, 1'b1, 100);
    chk("sat_done_cyc", 64'(done_cyc), 64'd41);
    chk("sat_ncore", 64'(cb_q.size()), 64'd8);
    chk("sat_last_base", 64'(cb_q[$]), 64'd14);
    chk("sat_nfeed", 64'(fb_q.size()), 64'd32);

    // Odd size 5
    run(5'd5, 1'b1, 50);
    chk("odd_done_cyc", 64'(done_cyc), 64'd10);
    chk("odd_last_cmask", 64'(cm_q[$]), 64'h1);
    chk("odd_last_core_x", 64'(cx_q[$]), 64'h0000_0004);
    chk("odd_last_fmask", 64'(fm_q[$]), 64'h1);

    // Fill the store, then try one more load
    for (int i = 0; i < MAXP; i++) load_pt('{x: 16'(100 + i), y: 16'(i), z: 16'(i)});
    chk("full_load_ready", 64'(load_ready), 64'd0);
    load_pt('{x: 16'hdead, y: 16'hdead, z: 16'hdead});
    chk("full_load_ready2", 64'(load_ready), 64'd0);
    run(5'd16, 1'b0, 100);
    chk("full_done_cyc", 64'(done_cyc), 64'd41);
    chk("full_feed_x0", fx_q[0], 64'h0067_0066_0065_0064);
    chk("full_feed_x3", fx_q[3], 64'h0073_0072_0071_0070);

    // Reset while in FEED, then restart
    start = 1'b1; synthetic_mode = 1'b1; point_cloud_size = 5'd6;
    step();
    start = 1'b0;
    step();
    chk("rr_in_feed", 64'(feed_valid), 64'd1);
    reset = 1'b1;
    step();
    chk("rr_core_valid", 64'(core_valid), 64'd0);
    chk("rr_feed_valid", 64'(feed_valid), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_done", 64'(done), 64'd0);
    reset = 1'b0;
    run(5'd6, 1'b1, 50);
    chk("rr_done_cyc", 64'(done_cyc), 64'd10);
    chk("rr_ncore", 64'(cb_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("rr_core_base%0d", i), 64'(cb_q[i]), 64'(exp_cb[i]));
    run(5'd4, 1'b0, 30);
    chk("rr_kept_done_cyc", 64'(done_cyc), 64'd5);
    chk("rr_kept_feed_x0", fx_q[0], 64'h0067_0066_0065_0064);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
